// File: rtl/sprite_queue_pkg.sv
// sprite_pkg: shared types for the sprite draw queue.
//   sprite_entry_t : one queued draw command {id, x, y, scale}, 48 bits
//   OP_DRAW/OP_FLUSH : host opcodes
//   parser_state_t : command parser states
package sprite_pkg;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } sprite_entry_t;

  localparam logic [7:0] OP_DRAW  = 8'h01;
  localparam logic [7:0] OP_FLUSH = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_XH,
    ST_XL,
    ST_YH,
    ST_YL,
    ST_SC
  } parser_state_t;

endpackage

// File: rtl/sprite_queue_if.sv
// sprite_queue_if: host byte input plus FWFT dequeue interface of the sprite queue.
//   rx_data/rx_valid           : host command bytes (no backpressure)
//   sprite_queue_dequeue       : consumer pop pulse
//   sprite_queue_is_empty      : FIFO holds no entries
//   sprite_queue_sprite_*      : head entry fields
// master = byte source / consumer side, slave = sprite_queue.
interface sprite_queue_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        sprite_queue_dequeue;
  logic        sprite_queue_is_empty;
  logic [7:0]  sprite_queue_sprite_id;
  logic [15:0] sprite_queue_sprite_x;
  logic [15:0] sprite_queue_sprite_y;
  logic [7:0]  sprite_queue_sprite_scale;

  modport master (
    output rx_data,
    output rx_valid,
    output sprite_queue_dequeue,
    input  sprite_queue_is_empty,
    input  sprite_queue_sprite_id,
    input  sprite_queue_sprite_x,
    input  sprite_queue_sprite_y,
    input  sprite_queue_sprite_scale
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  sprite_queue_dequeue,
    output sprite_queue_is_empty,
    output sprite_queue_sprite_id,
    output sprite_queue_sprite_x,
    output sprite_queue_sprite_y,
    output sprite_queue_sprite_scale
  );

endinterface

// File: rtl/sprite_queue_fifo.sv
// sprite_fifo: first-word-fall-through FIFO of sprite_entry_t.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push/i_push_data : write an entry (dropped when full unless a pop frees a slot)
//   i_pop          : advance head (ignored when empty)
//   i_flush        : clear pointers and count; wins over push/pop
//   o_head         : head entry, combinational; forced to zero while empty
//   o_count/o_full/o_empty : occupancy
module sprite_fifo
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  sprite_entry_t          i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output sprite_entry_t          o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  sprite_entry_t   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_pop_ok;
  logic            w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;
  // A same-edge pop frees the slot the push needs, so full only blocks a lone push.
  assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sprite_queue.sv
// sprite_queue: parses host command bytes into sprite draw entries and buffers
// them in a FWFT FIFO for the sprite distributor.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : rx_data/rx_valid in, dequeue in, is_empty and head fields out
//   count          : entries held (0..DEPTH)
//   busy           : parser mid-packet
//   overflow       : pulse, completed DRAW dropped because FIFO full
//   bad_dequeue    : pulse, dequeue while empty
// Packets: 0x01 id xh xl yh yl scale (DRAW), 0x02 (FLUSH); other opcodes ignored.
// Optional macro SPRITE_QUEUE_TIMEOUT_EN: abort a partial packet after RX_TIMEOUT
// idle cycles; when undefined the parser waits indefinitely.
module sprite_queue
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH = 32
`ifdef SPRITE_QUEUE_TIMEOUT_EN
  ,
  parameter int unsigned RX_TIMEOUT = 1024
`endif
) (
  input  logic                   clock,
  input  logic                   reset_n,
  sprite_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   bad_dequeue
);

  parser_state_t r_state;
  parser_state_t w_state_nxt;
  logic [7:0]    r_stage_id;
  logic [15:0]   r_stage_x;
  logic [15:0]   r_stage_y;
  logic          w_push;
  logic          w_flush;
  logic          w_timeout;
  sprite_entry_t w_push_data;
  sprite_entry_t w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          r_overflow;
  logic          r_bad_dequeue;

`ifdef SPRITE_QUEUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);
  logic [TW-1:0] r_idle_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               r_idle_cnt <= '0;
    else if (r_state == ST_IDLE || bus.rx_valid) r_idle_cnt <= '0;
    else                                        r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  // Fires on the RX_TIMEOUT-th consecutive idle cycle of a partial packet.
  assign w_timeout = (r_state != ST_IDLE) && !bus.rx_valid &&
                     (r_idle_cnt == TW'(RX_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.rx_valid) begin
      unique case (r_state)
        ST_IDLE: if (bus.rx_data == OP_DRAW) w_state_nxt = ST_ID;
        ST_ID:   w_state_nxt = ST_XH;
        ST_XH:   w_state_nxt = ST_XL;
        ST_XL:   w_state_nxt = ST_YH;
        ST_YH:   w_state_nxt = ST_YL;
        ST_YL:   w_state_nxt = ST_SC;
        ST_SC:   w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FLUSH is only an opcode in IDLE; 0x02 inside a packet is data.
  always_comb begin
    busy    = (r_state != ST_IDLE);
    w_push  = bus.rx_valid && (r_state == ST_SC);
    w_flush = bus.rx_valid && (r_state == ST_IDLE) && (bus.rx_data == OP_FLUSH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stage_id <= '0;
      r_stage_x  <= '0;
      r_stage_y  <= '0;
    end else if (w_timeout) begin
      r_stage_id <= '0;
      r_stage_x  <= '0;
      r_stage_y  <= '0;
    end else if (bus.rx_valid) begin
      case (r_state)
        ST_ID:   r_stage_id      <= bus.rx_data;
        ST_XH:   r_stage_x[15:8] <= bus.rx_data;
        ST_XL:   r_stage_x[7:0]  <= bus.rx_data;
        ST_YH:   r_stage_y[15:8] <= bus.rx_data;
        ST_YL:   r_stage_y[7:0]  <= bus.rx_data;
        default: ;
      endcase
    end
  end

  assign w_push_data = '{id: r_stage_id, x: r_stage_x, y: r_stage_y, scale: bus.rx_data};

  sprite_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (bus.sprite_queue_dequeue),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // A dequeue while full always pops, so it rescues a same-edge push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow    <= 1'b0;
      r_bad_dequeue <= 1'b0;
    end else begin
      r_overflow    <= w_push && w_full && !bus.sprite_queue_dequeue;
      r_bad_dequeue <= bus.sprite_queue_dequeue && w_empty && !w_flush;
    end
  end

  assign count                         = w_count;
  assign overflow                      = r_overflow;
  assign bad_dequeue                   = r_bad_dequeue;
  assign bus.sprite_queue_is_empty     = w_empty;
  assign bus.sprite_queue_sprite_id    = w_head.id;
  assign bus.sprite_queue_sprite_x     = w_head.x;
  assign bus.sprite_queue_sprite_y     = w_head.y;
  assign bus.sprite_queue_sprite_scale = w_head.scale;

endmodule
